// File: rtl/seq_digit_adder.sv
// seq_digit_adder: multi-cycle add/sub of WIDTH-bit operands, DIGIT bits per clock, start/ready/done handshake
module seq_digit_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_in_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             c_out_o,
  output logic             ovf_o
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("seq_digit_adder: need 1 <= DIGIT <= WIDTH and WIDTH %% DIGIT == 0");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [WIDTH-1:0]  a_q, b_q, res_q, res_d, sum_q;
  logic              cy_q, cy_d, cout_q, ovf_q, done_q, last;
  logic [DIGIT-1:0]  dig_d;
  always_comb begin
    {cy_d, dig_d} = {1'b0, a_q[cnt_q*DIGIT +: DIGIT]} + {1'b0, b_q[cnt_q*DIGIT +: DIGIT]}
                  + (DIGIT+1)'(cy_q);
    res_d = res_q;
    res_d[cnt_q*DIGIT +: DIGIT] = dig_d;
    last = cnt_q == CW'(N - 1);
  end
  // b_q holds the already-inverted operand in subtract mode so RUN is a plain add
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cy_q    <= 1'b0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start_i) begin
          a_q     <= a_i;
          b_q     <= sub_i ? ~b_i : b_i;
          cy_q    <= sub_i ^ c_in_i;
          cnt_q   <= '0;
          state_q <= RUN;
        end
        RUN: begin
          res_q <= res_d;
          cy_q  <= cy_d;
          cnt_q <= last ? '0 : cnt_q + CW'(1);
          if (last) begin
            state_q <= DONE;
            sum_q   <= res_d;
            cout_q  <= cy_d;
            ovf_q   <= cy_d ^ a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ res_d[WIDTH-1];
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign ready_o = state_q == IDLE;
  assign done_o  = done_q;
  assign sum_o   = sum_q;
  assign c_out_o = cout_q;
  assign ovf_o   = ovf_q;
endmodule

// File: tb/tb_seq_digit_adder.sv
// tb_seq_digit_adder: scoreboard bench for WIDTH=8/DIGIT=2 plus WIDTH=3 with DIGIT=1 and DIGIT=3
module tb_seq_digit_adder;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic       start8 = 0, sub8 = 0, c8 = 0, rdy8, done8, co8, ov8;
  logic [7:0] a8 = 0, b8 = 0, sum8;
  logic       start3 = 0, sub3 = 0, c3 = 0;
  logic [2:0] a3 = 0, b3 = 0, sum3a, sum3b;
  logic       rdy3a, done3a, co3a, ov3a, rdy3b, done3b, co3b, ov3b;
  seq_digit_adder #(.WIDTH(8), .DIGIT(2)) u8 (.clk(clk), .rst(rst), .start_i(start8), .sub_i(sub8),
    .a_i(a8), .b_i(b8), .c_in_i(c8), .ready_o(rdy8), .done_o(done8), .sum_o(sum8), .c_out_o(co8), .ovf_o(ov8));
  seq_digit_adder #(.WIDTH(3), .DIGIT(1)) u3a (.clk(clk), .rst(rst), .start_i(start3), .sub_i(sub3),
    .a_i(a3), .b_i(b3), .c_in_i(c3), .ready_o(rdy3a), .done_o(done3a), .sum_o(sum3a), .c_out_o(co3a), .ovf_o(ov3a));
  seq_digit_adder #(.WIDTH(3), .DIGIT(3)) u3b (.clk(clk), .rst(rst), .start_i(start3), .sub_i(sub3),
    .a_i(a3), .b_i(b3), .c_in_i(c3), .ready_o(rdy3b), .done_o(done3b), .sum_o(sum3b), .c_out_o(co3b), .ovf_o(ov3b));

  typedef struct {int v; int c;} exp_t;
  exp_t q8[$], q3a[$], q3b[$];
  exp_t e8, e3a, e3b;
  int   held8 = 0;
  logic rst_seen = 1'b1;
  always @(posedge clk) rst_seen <= rst;

  // result packed as {ovf, c_out, sum}, from signed/unsigned integer arithmetic
  function automatic int model(int w, int a, int b, int c, int s);
    int half = 1 << (w - 1);
    int full = 1 << w;
    int sa = a >= half ? a - full : a;
    int sb = b >= half ? b - full : b;
    int r  = s != 0 ? a - b - c : a + b + c;
    int sr = s != 0 ? sa - sb - c : sa + sb + c;
    int ov = (sr < -half || sr >= half) ? 1 : 0;
    int co = s != 0 ? (r >= 0 ? 1 : 0) : (r >= full ? 1 : 0);
    return (ov << (w + 1)) | (co << w) | (r & (full - 1));
  endfunction

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_seen) begin
      held8 = 0;
      q8.delete();
      q3a.delete();
      q3b.delete();
    end
    if (done8) begin
      if (q8.size() == 0) chk("spurious_done8", q8.size(), 1);
      else begin
        e8 = q8.pop_front();
        chk("result8", 32'({ov8, co8, sum8}), e8.v);
        chk("latency8", cyc, e8.c);
        held8 = e8.v;
      end
    end else chk("hold8", 32'({ov8, co8, sum8}), held8);
    if (done3a) begin
      if (q3a.size() == 0) chk("spurious_done3a", q3a.size(), 1);
      else begin
        e3a = q3a.pop_front();
        chk("result3a", 32'({ov3a, co3a, sum3a}), e3a.v);
        chk("latency3a", cyc, e3a.c);
      end
    end
    if (done3b) begin
      if (q3b.size() == 0) chk("spurious_done3b", q3b.size(), 1);
      else begin
        e3b = q3b.pop_front();
        chk("result3b", 32'({ov3b, co3b, sum3b}), e3b.v);
        chk("latency3b", cyc, e3b.c);
      end
    end
  end

  task automatic go8(logic [7:0] a, logic [7:0] b, logic c, logic s, bit garble);
    int t = 0;
    while (!rdy8 && t < 20) begin @(negedge clk); t++; end
    if (!rdy8) chk("ready8_timeout", 32'(rdy8), 1);
    a8 = a; b8 = b; c8 = c; sub8 = s; start8 = 1'b1;
    q8.push_back('{model(8, a, b, c, s), cyc + 5});
    @(negedge clk);
    start8 = 1'b0;
    if (garble) begin
      a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom); sub8 = 1'($urandom);
    end
  endtask

  task automatic go3(int a, int b, int c, int s);
    int t = 0;
    while (!(rdy3a && rdy3b) && t < 20) begin @(negedge clk); t++; end
    if (!(rdy3a && rdy3b)) chk("ready3_timeout", 32'(rdy3a && rdy3b), 1);
    a3 = 3'(a); b3 = 3'(b); c3 = 1'(c); sub3 = 1'(s); start3 = 1'b1;
    q3a.push_back('{model(3, a, b, c, s), cyc + 4});
    q3b.push_back('{model(3, a, b, c, s), cyc + 2});
    @(negedge clk);
    start3 = 1'b0;
    a3 = 3'($urandom); b3 = 3'($urandom);
  endtask

  initial begin
    int t;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_ready8", 32'(rdy8), 1);
    chk("reset_done8", 32'(done8), 0);
    chk("reset_out8", 32'({ov8, co8, sum8}), 0);
    chk("reset_ready3", 32'({rdy3a, rdy3b}), 3);
    @(negedge clk);
    go8(8'h7F, 8'h01, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      chk("busy8", 32'(rdy8), 0);
      @(negedge clk);
    end
    chk("ready8_after_done", 32'(rdy8), 1);
    go8(8'hFF, 8'h01, 0, 0, 1);
    go8(8'hFF, 8'hFF, 1, 0, 1);
    go8(8'h05, 8'h07, 0, 1, 1);
    go8(8'h80, 8'h01, 0, 1, 1);
    go8(8'h10, 8'h0F, 1, 1, 1);
    go8(8'h12, 8'h34, 0, 0, 0);
    a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    go8(8'h55, 8'h22, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready8", 32'(rdy8), 1);
    chk("abort_done8", 32'(done8), 0);
    chk("abort_out8", 32'({ov8, co8, sum8}), 0);
    @(negedge clk);
    go8(8'h01, 8'h01, 0, 0, 0);
    repeat (40) go8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1);
    for (int s = 0; s < 2; s++)
      for (int c = 0; c < 2; c++)
        for (int a = 0; a < 8; a++)
          for (int b = 0; b < 8; b++) go3(a, b, c, s);
    t = 0;
    while ((q8.size() + q3a.size() + q3b.size()) != 0 && t < 50) begin @(negedge clk); t++; end
    chk("drain", q8.size() + q3a.size() + q3b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
